// File: rtl/jump_motion_engine.sv
// -----------------------------------------------------------------------------
// jump_motion_engine
//
// Purpose:
//   Turns a raw jump button plus the frame-rate jump-window strobe into player
//   vertical motion. The button is synchronised and debounced. An accepted
//   press is latched as "pending". The next frame tick launches a jump. After
//   that, height and velocity are integrated once per frame until the player
//   lands.
//
// Ports:
//   proc_clk    in   1         sole clock
//   reset       in   1         synchronous, active-high reset
//   can_jump    in   1         frame window strobe (1..N cycles high per frame)
//   jump_btn    in   1         raw asynchronous jump button, active-high
//   height      out  HEIGHT_W  height above ground (unsigned, saturating)
//   velocity    out  VEL_W     signed vertical velocity, positive = up
//   airborne    out  1         high while ascending or descending
//   jump_start  out  1         one-cycle pulse when a jump launches
//   landed      out  1         one-cycle pulse when height returns to 0
//
// Optional feature:
//   DOUBLE_JUMP_EN - when defined, one extra launch is allowed per airtime.
//   The extra launch is re-armed on landing. When undefined, presses made while
//   airborne are dropped and no extra state flop exists.
// -----------------------------------------------------------------------------
module jump_motion_engine #(
  parameter int HEIGHT_W        = 10,
  parameter int VEL_W           = 8,
  parameter int JUMP_VEL        = 20,
  parameter int GRAVITY         = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                       proc_clk,
  input  logic                       reset,
  input  logic                       can_jump,
  input  logic                       jump_btn,
  output logic        [HEIGHT_W-1:0] height,
  output logic signed [VEL_W-1:0]    velocity,
  output logic                       airborne,
  output logic                       jump_start,
  output logic                       landed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The sum must hold a full-range unsigned height and a full-range signed
  // velocity without wrapping, whichever of the two is wider.
  localparam int SUM_W = ((HEIGHT_W + 1 > VEL_W) ? HEIGHT_W + 1 : VEL_W) + 1;
  localparam logic signed [SUM_W-1:0] H_MAX = SUM_W'((2 ** HEIGHT_W) - 1);

  localparam logic signed [VEL_W-1:0] LAUNCH_V = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_W   = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   VMIN_W   = {2'b11, {(VEL_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    GROUND,
    ASCEND,
    DESCEND
  } state_e;

  state_e                    state_q;
  logic                      syncMeta_q;
  logic                      syncOut_q;
  logic                      btnLevel_q;
  logic [CNT_W-1:0]          dbCount_q;
  logic                      canJumpPrev_q;
  logic                      pending_q;
  logic        [HEIGHT_W-1:0] height_q;
  logic signed [VEL_W-1:0]   velocity_q;
  logic                      airborne_q;
  logic                      jumpStart_q;
  logic                      landed_q;
`ifdef DOUBLE_JUMP_EN
  logic                      extraUsed_q;
`endif

  logic                      tick;
  logic                      dbDiffer;
  logic                      dbAccept;
  logic                      pressEvent;
  logic                      pressAllowed;
  logic signed [SUM_W-1:0]   heightExt;
  logic signed [SUM_W-1:0]   velExt;
  logic signed [SUM_W-1:0]   heightSum;
  logic        [HEIGHT_W-1:0] height_d;
  logic signed [VEL_W:0]     velWide;
  logic signed [VEL_W-1:0]   velocity_d;
  logic                      landNow;
  logic                      velNonPos;

  // Frame tick, button-edge detection, and the saturating height/velocity
  // arithmetic shared by the ASCEND and DESCEND states.
  always_comb begin
    tick       = can_jump & ~canJumpPrev_q;
    dbDiffer   = (syncOut_q != btnLevel_q);
    dbAccept   = dbDiffer && (dbCount_q == CNT_LAST);
    pressEvent = dbAccept && syncOut_q;

`ifdef DOUBLE_JUMP_EN
    pressAllowed = (state_q == GROUND) || !extraUsed_q;
`else
    pressAllowed = (state_q == GROUND);
`endif

    heightExt = $signed({{(SUM_W - HEIGHT_W){1'b0}}, height_q});
    velExt    = $signed({{(SUM_W - VEL_W){velocity_q[VEL_W-1]}}, velocity_q});
    heightSum = heightExt + velExt;
    landNow   = heightSum[SUM_W-1] || (heightSum == '0);

    if (heightSum > H_MAX) begin
      height_d = '1;
    end else if (heightSum[SUM_W-1]) begin
      height_d = '0;
    end else begin
      height_d = heightSum[HEIGHT_W-1:0];
    end

    velWide = $signed({velocity_q[VEL_W-1], velocity_q}) - GRAV_W;
    if (velWide < VMIN_W) begin
      velocity_d = VMIN_W[VEL_W-1:0];
    end else begin
      velocity_d = velWide[VEL_W-1:0];
    end
    velNonPos = velocity_d[VEL_W-1] || (velocity_d == '0);
  end

  // Two-flop synchroniser followed by the debouncer. The accepted level flips
  // only after the synchronised input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      btnLevel_q <= 1'b0;
      dbCount_q  <= '0;
    end else begin
      syncMeta_q <= jump_btn;
      syncOut_q  <= syncMeta_q;
      if (!dbDiffer) begin
        dbCount_q <= '0;
      end else if (dbAccept) begin
        btnLevel_q <= syncOut_q;
        dbCount_q  <= '0;
      end else begin
        dbCount_q <= dbCount_q + CNT_W'(1);
      end
    end
  end

  // Motion FSM. It advances only on frame ticks. canJumpPrev_q resets high so
  // that a window already open across reset does not count as a tick.
  // A pending press is consumed by a tick in the same block. A new press is
  // recorded last, so a press arriving on a tick cycle survives to the next
  // tick. Landing keeps any pending press, so a relaunch happens one tick later.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state_q       <= GROUND;
      canJumpPrev_q <= 1'b1;
      pending_q     <= 1'b0;
      height_q      <= '0;
      velocity_q    <= '0;
      airborne_q    <= 1'b0;
      jumpStart_q   <= 1'b0;
      landed_q      <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      extraUsed_q   <= 1'b0;
`endif
    end else begin
      canJumpPrev_q <= can_jump;
      jumpStart_q   <= 1'b0;
      landed_q      <= 1'b0;

      if (tick) begin
        case (state_q)
          GROUND: begin
            if (pending_q) begin
              velocity_q  <= LAUNCH_V;
              height_q    <= '0;
              pending_q   <= 1'b0;
              jumpStart_q <= 1'b1;
              airborne_q  <= 1'b1;
              state_q     <= ASCEND;
            end
          end
          ASCEND: begin
`ifdef DOUBLE_JUMP_EN
            if (pending_q) begin
              velocity_q  <= LAUNCH_V;
              pending_q   <= 1'b0;
              extraUsed_q <= 1'b1;
              jumpStart_q <= 1'b1;
            end else
`endif
            begin
              height_q   <= height_d;
              velocity_q <= velocity_d;
              if (velNonPos) begin
                state_q <= DESCEND;
              end
            end
          end
          DESCEND: begin
            if (landNow) begin
              height_q   <= '0;
              velocity_q <= '0;
              landed_q   <= 1'b1;
              airborne_q <= 1'b0;
              state_q    <= GROUND;
`ifdef DOUBLE_JUMP_EN
              extraUsed_q <= 1'b0;
            end else if (pending_q) begin
              velocity_q  <= LAUNCH_V;
              pending_q   <= 1'b0;
              extraUsed_q <= 1'b1;
              jumpStart_q <= 1'b1;
              state_q     <= ASCEND;
`endif
            end else begin
              height_q   <= height_d;
              velocity_q <= velocity_d;
            end
          end
          default: begin
            state_q <= GROUND;
          end
        endcase
      end

      if (pressEvent && pressAllowed) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign height     = height_q;
  assign velocity   = velocity_q;
  assign airborne   = airborne_q;
  assign jump_start = jumpStart_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_jump_motion_engine.sv
// -----------------------------------------------------------------------------
// tb_jump_motion_engine
//
// Two engines share one stimulus stream. Engine A uses small launch velocity
// 4 with 10-bit height. Engine B uses launch velocity 127 with 6-bit height,
// so its height saturates at 63. A behavioural model of each engine is stepped
// every cycle and compared with the outputs, alongside directed scenarios with
// hand-derived expected values. DOUBLE_JUMP_EN selects the matching model rules.
// -----------------------------------------------------------------------------
module tb_jump_motion_engine;

`ifdef DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif
  localparam int DB   = 4;
  localparam int GRAV = 1;
  localparam int VMIN = -128;

  logic       proc_clk = 1'b0;
  logic       reset;
  logic       can_jump;
  logic       jump_btn;
  logic [9:0] heightA;
  logic [7:0] velocityA;
  logic       airborneA, jumpStartA, landedA;
  logic [5:0] heightB;
  logic [7:0] velocityB;
  logic       airborneB, jumpStartB, landedB;

  // Free-running processor clock.
  always #5 proc_clk = ~proc_clk;

  jump_motion_engine #(
    .HEIGHT_W(10), .VEL_W(8), .JUMP_VEL(4), .GRAVITY(1), .DEBOUNCE_CYCLES(4)
  ) dutA (
    .proc_clk(proc_clk), .reset(reset), .can_jump(can_jump), .jump_btn(jump_btn),
    .height(heightA), .velocity(velocityA), .airborne(airborneA),
    .jump_start(jumpStartA), .landed(landedA)
  );

  jump_motion_engine #(
    .HEIGHT_W(6), .VEL_W(8), .JUMP_VEL(127), .GRAVITY(1), .DEBOUNCE_CYCLES(4)
  ) dutB (
    .proc_clk(proc_clk), .reset(reset), .can_jump(can_jump), .jump_btn(jump_btn),
    .height(heightB), .velocity(velocityB), .airborne(airborneB),
    .jump_start(jumpStartB), .landed(landedB)
  );

  // Behavioural state. st: 0 on ground, 1 rising, 2 falling.
  typedef struct {
    int s1, s2, lvl, cnt, prev, pending, st, h, v, extra, js, ld;
  } model_t;

  model_t mA, mB;
  int checks = 0;
  int errors = 0;
  int jsCountA = 0, ldCountA = 0, ldCountB = 0, maxB = 0;

  function automatic int clampInt(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Reference model. Input button history flows through two delay stages. The
  // accepted level changes after DB disagreeing samples. Flight follows
  // h += v, v -= GRAV, clamped to the legal ranges.
  function automatic model_t modelStep(input model_t m, input bit rst, input bit cj,
                                       input bit btn, input int hMax, input int jv);
    model_t n;
    bit tick, press, allowed;
    n = m;
    if (rst) begin
      n.s1 = 0; n.s2 = 0; n.lvl = 0; n.cnt = 0; n.prev = 1; n.pending = 0;
      n.st = 0; n.h = 0; n.v = 0; n.extra = 0; n.js = 0; n.ld = 0;
      return n;
    end
    tick   = cj && (m.prev == 0);
    n.prev = cj ? 1 : 0;
    n.js   = 0;
    n.ld   = 0;
    press  = 1'b0;
    if (m.s2 == m.lvl) n.cnt = 0;
    else if (m.cnt + 1 >= DB) begin
      n.lvl = m.s2; n.cnt = 0; press = (m.s2 != 0);
    end else n.cnt = m.cnt + 1;
    n.s1 = btn ? 1 : 0;
    n.s2 = m.s1;
    allowed = (m.st == 0) || (DJ && m.extra == 0);
    if (tick) begin
      if (m.st == 0) begin
        if (m.pending != 0) begin
          n.v = jv; n.h = 0; n.pending = 0; n.js = 1; n.st = 1;
        end
      end else if (m.st == 2 && m.h + m.v <= 0) begin
        n.h = 0; n.v = 0; n.ld = 1; n.st = 0; n.extra = 0;
      end else if (DJ && m.pending != 0) begin
        n.v = jv; n.pending = 0; n.extra = 1; n.js = 1; n.st = 1;
      end else begin
        n.h = clampInt(m.h + m.v, 0, hMax);
        n.v = clampInt(m.v - GRAV, VMIN, 127);
        if (m.st == 1 && n.v <= 0) n.st = 2;
      end
    end
    if (press && allowed) n.pending = 1;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit cj, input bit b);
    reset    = r;
    can_jump = cj;
    jump_btn = b;
    mA = modelStep(mA, r, cj, b, 1023, 4);
    mB = modelStep(mB, r, cj, b, 63, 127);
    @(posedge proc_clk);
    #1;
    checkOutput("a_height",     int'(heightA),            mA.h);
    checkOutput("a_velocity",   int'($signed(velocityA)), mA.v);
    checkOutput("a_airborne",   int'(airborneA),          (mA.st != 0) ? 1 : 0);
    checkOutput("a_jump_start", int'(jumpStartA),         mA.js);
    checkOutput("a_landed",     int'(landedA),            mA.ld);
    checkOutput("b_height",     int'(heightB),            mB.h);
    checkOutput("b_velocity",   int'($signed(velocityB)), mB.v);
    checkOutput("b_airborne",   int'(airborneB),          (mB.st != 0) ? 1 : 0);
    checkOutput("b_jump_start", int'(jumpStartB),         mB.js);
    checkOutput("b_landed",     int'(landedB),            mB.ld);
    if (jumpStartA === 1'b1) jsCountA++;
    if (landedA === 1'b1) ldCountA++;
    if (landedB === 1'b1) ldCountB++;
    if (int'(heightB) > maxB) maxB = int'(heightB);
  endtask

  task automatic runWindow(input int len, input int gap);
    for (int i = 0; i < len; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Hold the button long enough to be accepted, then release until the
  // accepted level has dropped again.
  task automatic pressButton(input int holdCycles);
    for (int i = 0; i < holdCycles; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int expHeights[9];
    int js0, ld0;
    int cjLeft, gapLeft;
    bit cj, b, r;

    expHeights = '{4, 7, 9, 10, 10, 9, 7, 4, 0};

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_height", int'(heightA), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Full jump with 3-cycle windows.
    js0 = jsCountA;
    pressButton(6);
    runWindow(3, 3);
    checkOutput("t2_launch_vel", int'($signed(velocityA)), 4);
    ld0 = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) ld0 = ldCountA;
      runWindow(3, 3);
      checkOutput("t2_height", int'(heightA), expHeights[i]);
    end
    checkOutput("t2_jump_starts", jsCountA - js0, 1);
    checkOutput("t2_landed_final", ldCountA - ld0, 1);
    checkOutput("t2_airborne", int'(airborneA), 0);

    // Reset in mid-flight.
    pressButton(6);
    runWindow(3, 3);
    runWindow(3, 3);
    runWindow(3, 3);
    checkOutput("t1_height_before", int'(heightA), 7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_height", int'(heightA), 0);
    checkOutput("t1_velocity", int'(velocityA), 0);
    checkOutput("t1_airborne", int'(airborneA), 0);
    checkOutput("t1_jump_start", int'(jumpStartA), 0);
    checkOutput("t1_landed", int'(landedA), 0);
    js0 = jsCountA;
    for (int i = 0; i < 3; i++) runWindow(2, 3);
    checkOutput("t1_no_pending", jsCountA - js0, 0);

    // Short glitch must not be accepted.
    js0 = jsCountA;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) runWindow(3, 3);
    checkOutput("t3_glitch_js", jsCountA - js0, 0);
    checkOutput("t3_glitch_h", int'(heightA), 0);

    // A long window produces a single update.
    pressButton(6);
    runWindow(3, 3);
    runWindow(10, 3);
    checkOutput("t4_height", int'(heightA), 4);
    checkOutput("t4_velocity", int'($signed(velocityA)), 3);

    // Press while airborne at height 9.
    runWindow(3, 3);
    runWindow(3, 3);
    checkOutput("t5_height9", int'(heightA), 9);
    js0 = jsCountA;
    pressButton(6);
    runWindow(3, 3);
    checkOutput("t5_air_js", jsCountA - js0, DJ ? 1 : 0);
    checkOutput("t5_air_vel", int'($signed(velocityA)), DJ ? 4 : 0);
    checkOutput("t5_air_h", int'(heightA), DJ ? 9 : 10);
    js0 = jsCountA;
    ld0 = ldCountA;
    pressButton(6);
    for (int w = 0; w < 40 && mA.st != 0; w++) runWindow(3, 3);
    checkOutput("t5_second_press_js", jsCountA - js0, 0);
    checkOutput("t5_landed", ldCountA - ld0, 1);

    // Saturating engine B must peak at 63 and come back down.
    for (int w = 0; w < 400 && !(mA.st == 0 && mB.st == 0); w++) runWindow(1, 3);
    checkOutput("t6_b_peak", maxB, 63);
    checkOutput("t6_b_height", int'(heightB), 0);
    checkOutput("t6_b_airborne", int'(airborneB), 0);
    checkOutput("t6_b_landed_seen", (ldCountB > 0) ? 1 : 0, 1);

    // Randomised windows, button activity and occasional resets.
    cjLeft = 0; gapLeft = 0; b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) b = ~b;
      if (cjLeft == 0 && gapLeft == 0) begin
        cjLeft  = int'($urandom_range(1, 4));
        gapLeft = int'($urandom_range(1, 6));
      end
      if (cjLeft > 0) begin
        cj = 1'b1; cjLeft--;
      end else begin
        cj = 1'b0; gapLeft--;
      end
      r = ($urandom_range(0, 399) == 0);
      applyStimulus(r, cj, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
